// File: rtl/coffee_brewer.sv
// coffee_brewer: brew sequencer downstream of the payment controller.
// Drives cup drop, grinder, heater and pump from a single phase down-counter,
// acknowledges with coffee_ready / cup_out, and latches a fault on water loss.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for a rising edge on prepare_coffee
//   S_DROP   | one-cycle cup release pulse
//   S_GRIND  | grinder on for GRIND_CYC cycles
//   S_HEAT   | heater-only pre-heat for HEAT_CYC cycles
//   S_PUMP   | pump + heater for PUMP_CYC cycles
//   S_READY  | one-cycle coffee_ready pulse
//   S_REMOVE | waiting for REMOVE_CYC consecutive cycles without a cup
//   S_FAULT  | water lost; actuators off until water back and request low
module coffee_brewer #(
  parameter int GRIND_CYC  = 8,
  parameter int HEAT_CYC   = 16,
  parameter int PUMP_CYC   = 24,
  parameter int REMOVE_CYC = 4
) (
  input  logic clk4m,
  input  logic rst,
  input  logic prepare_coffee,
  input  logic water_ok,
  input  logic cup_present,
  output logic cup_drop,
  output logic grinder,
  output logic heater,
  output logic pump,
  output logic coffee_ready,
  output logic cup_out,
  output logic busy,
  output logic fault
);

  localparam int MAX_GH  = (GRIND_CYC > HEAT_CYC) ? GRIND_CYC : HEAT_CYC;
  localparam int MAX_PR  = (PUMP_CYC > REMOVE_CYC) ? PUMP_CYC : REMOVE_CYC;
  localparam int MAX_CYC = (MAX_GH > MAX_PR) ? MAX_GH : MAX_PR;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] GRIND_LD  = CW'(GRIND_CYC - 1);
  localparam logic [CW-1:0] HEAT_LD   = CW'(HEAT_CYC - 1);
  localparam logic [CW-1:0] PUMP_LD   = CW'(PUMP_CYC - 1);
  localparam logic [CW-1:0] REMOVE_LD = CW'(REMOVE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DROP,
    S_GRIND,
    S_HEAT,
    S_PUMP,
    S_READY,
    S_REMOVE,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prep_q;
  logic          cup_out_q, cup_out_d;
  logic          start;
  logic          cnt_zero;

  // prep_q resets high so a request held through reset is not seen as an edge
  assign start    = prepare_coffee & ~prep_q;
  assign cnt_zero = (cnt_q == '0);

  // State, phase counter, request history and cup_out pulse registers
  always_ff @(posedge clk4m) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prep_q    <= 1'b1;
      cup_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prep_q    <= prepare_coffee;
      cup_out_q <= cup_out_d;
    end
  end

  // Next-state and counter load/decrement; water loss outranks phase expiry
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cup_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = water_ok ? S_DROP : S_FAULT;
        end
      end
      S_DROP: begin
        state_d = S_GRIND;
        cnt_d   = GRIND_LD;
      end
      S_GRIND: begin
        if (cnt_zero) begin
          state_d = S_HEAT;
          cnt_d   = HEAT_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HEAT: begin
        if (!water_ok) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = S_PUMP;
          cnt_d   = PUMP_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PUMP: begin
        if (!water_ok) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_READY: begin
        state_d = S_REMOVE;
        cnt_d   = REMOVE_LD;
      end
      S_REMOVE: begin
        if (cup_present) begin
          cnt_d = REMOVE_LD;
        end else if (cnt_zero) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          cup_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FAULT: begin
        cnt_d = '0;
        if (water_ok && !prepare_coffee) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign cup_drop     = (state_q == S_DROP);
  assign grinder      = (state_q == S_GRIND);
  assign heater       = (state_q == S_HEAT) || (state_q == S_PUMP);
  assign pump         = (state_q == S_PUMP);
  assign coffee_ready = (state_q == S_READY);
  assign cup_out      = cup_out_q;
  assign busy         = (state_q != S_IDLE);
  assign fault        = (state_q == S_FAULT);

endmodule

// File: tb/tb_coffee_brewer.sv
// tb_coffee_brewer: directed stimulus with an event scoreboard.
// Stimulus pushes expected output events (kind, cycle, info); a negedge
// monitor detects events on the DUT outputs and pops/compares them.
`timescale 1ns/1ps
module tb_coffee_brewer;

  logic clk4m;
  logic rst;
  logic prepare_coffee;
  logic water_ok;
  logic cup_present;
  logic cup_drop, grinder, heater, pump, coffee_ready, cup_out, busy, fault;

  coffee_brewer dut (
    .clk4m          (clk4m),
    .rst            (rst),
    .prepare_coffee (prepare_coffee),
    .water_ok       (water_ok),
    .cup_present    (cup_present),
    .cup_drop       (cup_drop),
    .grinder        (grinder),
    .heater         (heater),
    .pump           (pump),
    .coffee_ready   (coffee_ready),
    .cup_out        (cup_out),
    .busy           (busy),
    .fault          (fault)
  );

  localparam int K_BUSY_ON   = 0;
  localparam int K_DROP      = 1;
  localparam int K_FAULT_ON  = 2;
  localparam int K_READY     = 3;
  localparam int K_CUPOUT    = 4;
  localparam int K_FAULT_OFF = 5;
  localparam int K_BUSY_OFF  = 6;

  // grinder 8, heater 16+24, pump 24 cycles per complete brew
  localparam int READY_INFO  = (8 << 16) | (40 << 8) | 24;

  typedef struct {
    int kind;
    int cyc;
    int info;
  } ev_t;

  ev_t exq[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  int  gcnt  = 0;
  int  hcnt  = 0;
  int  pcnt  = 0;
  bit  busy_p  = 1'b0;
  bit  fault_p = 1'b0;

  initial clk4m = 1'b0;
  always #125 clk4m = ~clk4m;

  // cyc counts rising edges; output state after edge n is seen with cyc == n
  always @(posedge clk4m) cyc <= cyc + 1;

  task automatic push(input int kind, input int c, input int info);
    ev_t t;
    t.kind = kind;
    t.cyc  = c;
    t.info = info;
    exq.push_back(t);
  endtask

  task automatic got(input int kind, input int info);
    ev_t e;
    total++;
    if (exq.size() == 0) begin
      bad++;
      $display("FAIL event: got kind=%0d cyc=%0d info=%0h, required no event", kind, cyc, info);
    end else begin
      e = exq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.info != info) begin
        bad++;
        $display("FAIL event: got kind=%0d cyc=%0d info=%0h, required kind=%0d cyc=%0d info=%0h",
                 kind, cyc, info, e.kind, e.cyc, e.info);
      end
    end
  endtask

  // Monitor: turn output activity into events in a fixed per-cycle order
  always @(negedge clk4m) begin
    if (grinder === 1'b1) gcnt++;
    if (heater === 1'b1) hcnt++;
    if (pump === 1'b1) pcnt++;
    if (busy === 1'b1 && !busy_p) got(K_BUSY_ON, 0);
    if (cup_drop === 1'b1) begin
      got(K_DROP, 0);
      gcnt = 0;
      hcnt = 0;
      pcnt = 0;
    end
    if (fault === 1'b1 && !fault_p)
      got(K_FAULT_ON, {27'd0, cup_drop === 1'b1, grinder === 1'b1, heater === 1'b1,
                       pump === 1'b1, coffee_ready === 1'b1});
    if (coffee_ready === 1'b1) got(K_READY, (gcnt << 16) | (hcnt << 8) | pcnt);
    if (cup_out === 1'b1) got(K_CUPOUT, 0);
    if (fault !== 1'b1 && fault_p) got(K_FAULT_OFF, 0);
    if (busy !== 1'b1 && busy_p) got(K_BUSY_OFF, 0);
    busy_p  = (busy === 1'b1);
    fault_p = (fault === 1'b1);
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk4m);
      #1;
    end
  endtask

  // Raise the request now (sampled at edge cyc+1) and hold it for two edges
  task automatic start_brew();
    int e;
    e = cyc + 1;
    prepare_coffee = 1'b1;
    wait_cyc(e + 1);
    prepare_coffee = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    logic [7:0] v;
    v = {cup_drop, grinder, heater, pump, coffee_ready, cup_out, busy, fault};
    total++;
    if (v !== 8'h00) begin
      bad++;
      $display("FAIL %s: outputs=%b, required 00000000", name, v);
    end
  endtask

  task automatic push_full_brew(input int e);
    push(K_BUSY_ON,  e,      0);
    push(K_DROP,     e,      0);
    push(K_READY,    e + 49, READY_INFO);
    push(K_CUPOUT,   e + 54, 0);
    push(K_BUSY_OFF, e + 54, 0);
  endtask

  initial begin
    int e1, e2, e3, e4, e5, e6, guard;
    rst            = 1'b1;
    prepare_coffee = 1'b1;
    water_ok       = 1'b1;
    cup_present    = 1'b0;

    // Reset with request held high; releasing reset must not start a brew
    wait_cyc(3);
    check_all_zero("reset_state");
    rst = 1'b0;
    wait_cyc(10);
    prepare_coffee = 1'b0;
    wait_cyc(12);

    // Normal brew, cup gone at once; re-pulse during GRIND is ignored
    e1 = cyc + 1;
    push_full_brew(e1);
    start_brew();
    wait_cyc(e1 + 3);
    prepare_coffee = 1'b1;
    wait_cyc(e1 + 5);
    prepare_coffee = 1'b0;
    wait_cyc(e1 + 54);

    // Back-to-back brew starting the cycle after cup_out; cup lingers
    e2 = cyc + 1;
    cup_present = 1'b1;
    push(K_BUSY_ON,  e2,      0);
    push(K_DROP,     e2,      0);
    push(K_READY,    e2 + 49, READY_INFO);
    push(K_CUPOUT,   e2 + 79, 0);
    push(K_BUSY_OFF, e2 + 79, 0);
    start_brew();
    wait_cyc(e2 + 69);
    cup_present = 1'b0;
    wait_cyc(e2 + 71);
    cup_present = 1'b1;
    wait_cyc(e2 + 75);
    cup_present = 1'b0;
    wait_cyc(e2 + 85);

    // Water loss in PUMP, request held across restore, then released
    e3 = cyc + 1;
    push(K_BUSY_ON,   e3,      0);
    push(K_DROP,      e3,      0);
    push(K_FAULT_ON,  e3 + 30, 0);
    push(K_FAULT_OFF, e3 + 46, 0);
    push(K_BUSY_OFF,  e3 + 46, 0);
    start_brew();
    wait_cyc(e3 + 29);
    water_ok = 1'b0;
    wait_cyc(e3 + 32);
    prepare_coffee = 1'b1;
    wait_cyc(e3 + 35);
    water_ok = 1'b1;
    wait_cyc(e3 + 45);
    prepare_coffee = 1'b0;
    wait_cyc(e3 + 50);

    // Dry tank at the start edge: straight to FAULT, no cup drop
    water_ok = 1'b0;
    wait_cyc(e3 + 52);
    e4 = cyc + 1;
    push(K_BUSY_ON,   e4,     0);
    push(K_FAULT_ON,  e4,     0);
    push(K_FAULT_OFF, e4 + 4, 0);
    push(K_BUSY_OFF,  e4 + 4, 0);
    start_brew();
    wait_cyc(e4 + 3);
    water_ok = 1'b1;
    wait_cyc(e4 + 8);

    // Reset mid-brew with request held across reset release
    e5 = cyc + 1;
    push(K_BUSY_ON,  e5,      0);
    push(K_DROP,     e5,      0);
    push(K_BUSY_OFF, e5 + 20, 0);
    start_brew();
    wait_cyc(e5 + 19);
    rst = 1'b1;
    prepare_coffee = 1'b1;
    wait_cyc(e5 + 20);
    check_all_zero("reset_mid_brew");
    wait_cyc(e5 + 23);
    rst = 1'b0;
    wait_cyc(e5 + 33);
    prepare_coffee = 1'b0;
    wait_cyc(e5 + 35);

    // Fresh edge after reset gives a full brew
    e6 = cyc + 1;
    push_full_brew(e6);
    start_brew();
    wait_cyc(e6 + 60);

    guard = 0;
    while (exq.size() != 0 && guard < 200) begin
      @(posedge clk4m);
      #1;
      guard++;
    end
    total++;
    if (exq.size() != 0) begin
      bad++;
      $display("FAIL pending_events: %0d still expected, required 0 (next kind=%0d cyc=%0d)",
               exq.size(), exq[0].kind, exq[0].cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
